// File: rtl/rpc_cmd_splitter.sv
// Splits one long RPC DRAM command into sub-commands that never cross a row
// boundary, never exceed MaxBurst words and, optionally, stay MaxBurst-aligned.
module rpc_cmd_splitter #(
  parameter int AddrWidth  = 20,
  parameter int InLenWidth = 16,
  parameter int BlenWidth  = 6,
  parameter int ColWidth   = 10,
  parameter int MaxBurst   = 32,
  parameter int AlignBurst = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  in_write_i,
  input  logic [AddrWidth-1:0]  in_addr_i,
  input  logic [InLenWidth-1:0] in_len_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  out_write_o,
  output logic [AddrWidth-1:0]  out_addr_o,
  output logic [BlenWidth-1:0]  out_len_o,
  output logic                  out_last_o,
  output logic                  busy_o
);

  localparam int RemWidth = InLenWidth + 1;
  localparam int CntWidth = (RemWidth > ColWidth + 1) ? RemWidth : ColWidth + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_t;

  state_t                state_r;
  logic                  out_valid_r;
  logic                  out_write_r;
  logic [AddrWidth-1:0]  out_addr_r;
  logic [BlenWidth-1:0]  out_len_r;
  logic                  out_last_r;
  logic                  busy_r;
  logic [CntWidth-1:0]   rem_r;

  logic [CntWidth-1:0]   cur_n_s;
  logic [AddrWidth-1:0]  sel_addr_s;
  logic [CntWidth-1:0]   sel_rem_s;
  logic [CntWidth-1:0]   n_s;

  // Words that fit before the next row (or aligned) boundary, capped by what remains.
  function automatic logic [CntWidth-1:0] chunk_words(input logic [AddrWidth-1:0] a,
                                                      input logic [CntWidth-1:0]  r);
    logic [CntWidth-1:0] room_row;
    logic [CntWidth-1:0] room;
    room_row = (CntWidth'(1) << ColWidth) - CntWidth'(a[ColWidth-1:0]);
    if (AlignBurst != 0) begin
      room = CntWidth'(MaxBurst) - CntWidth'(a % AddrWidth'(MaxBurst));
    end else if (room_row < CntWidth'(MaxBurst)) begin
      room = room_row;
    end else begin
      room = CntWidth'(MaxBurst);
    end
    if (r < room) begin
      return r;
    end else begin
      return room;
    end
  endfunction

  // Address/remaining count the next sub-command is computed from; out_addr_r doubles as cur_addr.
  always_comb begin
    cur_n_s = CntWidth'(out_len_r) + CntWidth'(1);
    if (state_r == IDLE) begin
      sel_addr_s = in_addr_i;
      sel_rem_s  = CntWidth'(in_len_i) + CntWidth'(1);
    end else begin
      sel_addr_s = out_addr_r + AddrWidth'(cur_n_s);
      sel_rem_s  = rem_r - cur_n_s;
    end
    n_s = chunk_words(sel_addr_s, sel_rem_s);
  end

  // Splitter FSM with registered sub-command outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
      out_write_r <= 1'b0;
      out_addr_r  <= '0;
      out_len_r   <= '0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      rem_r       <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid_i) begin
            out_write_r <= in_write_i;
            out_addr_r  <= sel_addr_s;
            rem_r       <= sel_rem_s;
            out_len_r   <= BlenWidth'(n_s - CntWidth'(1));
            out_last_r  <= (n_s == sel_rem_s);
            out_valid_r <= 1'b1;
            busy_r      <= 1'b1;
            state_r     <= SPLIT;
          end
        end
        SPLIT: begin
          if (out_ready_i) begin
            if (out_last_r) begin
              out_valid_r <= 1'b0;
              busy_r      <= 1'b0;
              state_r     <= IDLE;
            end else begin
              out_addr_r  <= sel_addr_s;
              rem_r       <= sel_rem_s;
              out_len_r   <= BlenWidth'(n_s - CntWidth'(1));
              out_last_r  <= (n_s == sel_rem_s);
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = (state_r == IDLE) && !rst_i;
  assign out_valid_o = out_valid_r;
  assign out_write_o = out_write_r;
  assign out_addr_o  = out_addr_r;
  assign out_len_o   = out_len_r;
  assign out_last_o  = out_last_r;
  assign busy_o      = busy_r;

endmodule
